bram_index_arbiter: RTL and testbench

Shares one `bram_address_generator` pipeline (fp16 divide, then fp-to-fixed convert) among NUM_REQ bounding-box coordinate requesters. Round-robin arbitration issues one x-axis sample per cycle into the generator. Requester IDs are tracked in order through the fixed-latency pipeline. Each returned BRAM index is delivered with its requester ID through a back-pressurable response port. Credit-based issue control guarantees the response buffer never overflows, even though the generator pipeline has no back-pressure.

---
 rtl/bbox_pkg.sv | 14 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/bram_index_arbiter.sv | 142 ++++++++++++++
 tb/tb_bram_index_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bbox_pkg.sv
// rtl/bbox_pkg.sv - shared defaults and result-entry type for the bbox index path
package bbox_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int NUM_REQ_DEF    = 4;
    localparam int ID_W_DEF       = $clog2(NUM_REQ_DEF);

    typedef struct packed {
        logic [ID_W_DEF-1:0]       id;
        logic [DATA_WIDTH_DEF-1:0] index;
        logic                      overflow;
    } result_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO, simultaneous push/pop legal
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == DEPTH_C);
    assign do_pop    = pop && !empty;
    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/bram_index_arbiter.sv
// rtl/bram_index_arbiter.sv - round-robin, credit-limited sharing of one bram_address_generator
module bram_index_arbiter
    import bbox_pkg::*;
#(
    parameter int  DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int  NUM_REQ      = NUM_REQ_DEF,
    parameter int  MAX_INFLIGHT = 16,
    localparam int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         gen_x_data_out,
    output logic                          gen_read_value_out,
    input  logic [DATA_WIDTH-1:0]         gen_index_in,
    input  logic                          gen_index_valid_in,
    input  logic                          gen_index_overflow_in,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [ID_W-1:0]               resp_id,
    output logic [DATA_WIDTH-1:0]         resp_index,
    output logic                          resp_overflow,
    output logic [15:0]                   overflow_count,
    output logic                          orphan_err,
    output logic                          busy
);

    localparam int CW = $clog2(MAX_INFLIGHT) + 1;
    localparam int RW = ID_W + DATA_WIDTH + 1;
    localparam logic [CW-1:0] CREDIT_MAX = MAX_INFLIGHT[CW-1:0];

    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       winner;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  found;
    logic                  grant;
    logic                  resp_pop;
    logic [CW-1:0]         credit;
    logic [CW-1:0]         credit_next;
    logic                  tag_empty;
    logic                  tag_full;
    logic                  tag_pop;
    logic [ID_W-1:0]       tag_head;
    logic                  res_empty;
    logic                  res_full;
    logic [RW-1:0]         res_head;
    logic                  unused_full;

    // Second pass overrides the lowest requester with the lowest one at or above rr_ptr.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        win_data = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                found  = 1'b1;
                winner = ID_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
                winner = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign grant    = found && (credit < CREDIT_MAX);
    assign resp_pop = resp_valid && resp_ready;
    assign tag_pop  = gen_index_valid_in && !tag_empty;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant && (winner == ID_W'(i));
        end
    end

    // Credit spans pipeline plus result FIFO, so neither FIFO can overrun.
    assign credit_next = credit + {{(CW-1){1'b0}}, grant} - {{(CW-1){1'b0}}, resp_pop};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr             <= '0;
            credit             <= '0;
            busy               <= 1'b0;
            gen_read_value_out <= 1'b0;
            gen_x_data_out     <= '0;
            overflow_count     <= '0;
            orphan_err         <= 1'b0;
        end else begin
            credit             <= credit_next;
            busy               <= (credit_next != '0);
            gen_read_value_out <= grant;
            if (grant) begin
                gen_x_data_out <= win_data;
                rr_ptr         <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end
            if (gen_index_valid_in && tag_empty) begin
                orphan_err <= 1'b1;
            end
            if (tag_pop && gen_index_overflow_in && (overflow_count != 16'hFFFF)) begin
                overflow_count <= overflow_count + 16'd1;
            end
        end
    end

    sync_fifo #(.WIDTH(ID_W), .DEPTH(MAX_INFLIGHT)) u_tag_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (grant),
        .push_data (winner),
        .pop       (tag_pop),
        .head_data (tag_head),
        .empty     (tag_empty),
        .full      (tag_full)
    );

    sync_fifo #(.WIDTH(RW), .DEPTH(MAX_INFLIGHT)) u_result_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (tag_pop),
        .push_data ({tag_head, gen_index_in, gen_index_overflow_in}),
        .pop       (resp_pop),
        .head_data (res_head),
        .empty     (res_empty),
        .full      (res_full)
    );

    assign unused_full   = tag_full ^ res_full;
    assign resp_valid    = !res_empty;
    assign resp_id       = res_head[RW-1 -: ID_W];
    assign resp_index    = res_head[DATA_WIDTH:1];
    assign resp_overflow = res_head[0];

endmodule

// File: tb/tb_bram_index_arbiter.sv
// tb/tb_bram_index_arbiter.sv - randomized scoreboard bench for bram_index_arbiter
module tb_bram_index_arbiter;
    import bbox_pkg::*;

    localparam int DW  = 16;
    localparam int NR  = 4;
    localparam int MI  = 16;
    localparam int IW  = 2;
    localparam int LAT = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic [DW-1:0]   gen_x_data_out;
    logic            gen_read_value_out;
    logic [DW-1:0]   gen_index_in;
    logic            gen_index_valid_in;
    logic            gen_index_overflow_in;
    logic            resp_valid;
    logic            resp_ready;
    logic [IW-1:0]   resp_id;
    logic [DW-1:0]   resp_index;
    logic            resp_overflow;
    logic [15:0]     overflow_count;
    logic            orphan_err;
    logic            busy;

    always #5 clk = ~clk;

    bram_index_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_INFLIGHT(MI)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .req_valid             (req_valid),
        .req_data              (req_data),
        .req_ready             (req_ready),
        .gen_x_data_out        (gen_x_data_out),
        .gen_read_value_out    (gen_read_value_out),
        .gen_index_in          (gen_index_in),
        .gen_index_valid_in    (gen_index_valid_in),
        .gen_index_overflow_in (gen_index_overflow_in),
        .resp_valid            (resp_valid),
        .resp_ready            (resp_ready),
        .resp_id               (resp_id),
        .resp_index            (resp_index),
        .resp_overflow         (resp_overflow),
        .overflow_count        (overflow_count),
        .orphan_err            (orphan_err),
        .busy                  (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    result_t sb_q[$];
    int      ready_q[$];
    int      ret_t[$];
    logic    ret_o[$];
    int      outstanding = 0;
    int      pending     = 0;
    int      m_rr        = 0;
    int      m_ovf       = 0;
    logic    m_orphan    = 1'b0;

    logic          pv [LAT];
    logic [DW-1:0] pd [LAT];

    function automatic logic [DW-1:0] gen_idx(input logic [DW-1:0] x);
        return {x[7:0], x[15:8]} ^ 16'h5A3C;
    endfunction

    function automatic logic gen_ovf(input logic [DW-1:0] x);
        return x[15:14] == 2'b11;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive inputs and generator model at negedge, then check against the reference.
    task automatic step(input logic [NR-1:0] v, input logic rdy, input logic inj,
                        input logic rst, input int dmode, input logic [DW-1:0] d);
        logic [NR-1:0] exp_ready;
        logic [DW-1:0] samples [NR];
        logic          out_v;
        logic [DW-1:0] out_d;
        int            w;
        @(negedge clk);
        cyc++;
        out_v = pv[LAT-1];
        out_d = pd[LAT-1];
        for (int i = LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = gen_read_value_out;
        pd[0] = gen_x_data_out;
        if (rst) begin
            reset_n               = 1'b0;
            req_valid             = '0;
            resp_ready            = 1'b0;
            gen_index_valid_in    = 1'b0;
            gen_index_in          = '0;
            gen_index_overflow_in = 1'b0;
            for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
            sb_q.delete();
            ready_q.delete();
            ret_t.delete();
            ret_o.delete();
            outstanding = 0;
            pending     = 0;
            m_rr        = 0;
            m_ovf       = 0;
            m_orphan    = 1'b0;
            return;
        end
        reset_n = 1'b1;
        for (int i = 0; i < NR; i++) begin
            if (dmode == 1)      samples[i] = d;
            else if (dmode == 0) samples[i] = 16'($urandom) & 16'h7FFF;
            else                 samples[i] = 16'($urandom);
            req_data[i*DW +: DW] = samples[i];
        end
        req_valid             = v;
        resp_ready            = rdy;
        gen_index_valid_in    = out_v | inj;
        gen_index_in          = out_v ? gen_idx(out_d) : '0;
        gen_index_overflow_in = out_v & gen_ovf(out_d);
        #1;
        w = -1;
        if (outstanding < MI) begin
            for (int k = 0; k < NR; k++) begin
                if (w < 0 && ((v >> ((m_rr + k) % NR)) & 4'b0001) != 4'b0000) w = (m_rr + k) % NR;
            end
        end
        exp_ready = (w >= 0) ? (4'b0001 << w) : 4'b0000;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("busy", 32'(busy), 32'(outstanding != 0));
        check("resp_valid", 32'(resp_valid), 32'(ready_q.size() > 0 && ready_q[0] <= cyc));
        check("orphan_err", 32'(orphan_err), 32'(m_orphan));
        check("overflow_count", 32'(overflow_count), 32'(m_ovf));
        if (ready_q.size() > 0 && ready_q[0] <= cyc && rdy) begin
            void'(ready_q.pop_front());
            outstanding--;
        end
        if (inj && pending == 0) m_orphan = 1'b1;
        while (ret_t.size() > 0 && ret_t[0] == cyc) begin
            void'(ret_t.pop_front());
            if (ret_o.pop_front()) m_ovf++;
            pending--;
        end
        if (w >= 0) begin
            sb_q.push_back('{id: IW'(w), index: gen_idx(samples[w]), overflow: gen_ovf(samples[w])});
            ready_q.push_back(cyc + LAT + 2);
            ret_t.push_back(cyc + LAT + 1);
            ret_o.push_back(gen_ovf(samples[w]));
            outstanding++;
            pending++;
            m_rr = (w + 1) % NR;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (outstanding != 0 && n < 200) begin
            step(4'b0000, 1'b1, 1'b0, 1'b0, 0, 16'h0);
            n++;
        end
        if (outstanding != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d still outstanding after %0d cycles", outstanding, n);
        end
        step(4'b0000, 1'b1, 1'b0, 1'b0, 0, 16'h0);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    endtask

    // Response monitor: pops the scoreboard whenever the DUT hands over a result.
    initial begin
        result_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL resp_unexpected: got id %0d index %0h, expected no response", resp_id, resp_index);
                end else begin
                    e = sb_q.pop_front();
                    check("resp_id", 32'(resp_id), 32'(e.id));
                    check("resp_index", 32'(resp_index), 32'(e.index));
                    check("resp_overflow", 32'(resp_overflow), 32'(e.overflow));
                end
            end
        end
    end

    initial begin
        reset_n               = 1'b0;
        req_valid             = '0;
        req_data              = '0;
        resp_ready            = 1'b0;
        gen_index_valid_in    = 1'b0;
        gen_index_in          = '0;
        gen_index_overflow_in = 1'b0;
        step(4'b0000, 1'b0, 1'b0, 1'b1, 0, 16'h0);
        step(4'b0000, 1'b0, 1'b0, 1'b1, 0, 16'h0);
        #1;
        check("rst_gen_read", 32'(gen_read_value_out), 32'd0);
        check("rst_gen_x", 32'(gen_x_data_out), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_resp_index", 32'(resp_index), 32'd0);
        check("rst_resp_overflow", 32'(resp_overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        repeat (40) step(4'b1111, 1'b1, 1'b0, 1'b0, 0, 16'h0);
        drain();

        repeat (30) step(4'b1111, 1'b0, 1'b0, 1'b0, 0, 16'h0);
        check("stall_req_ready", 32'(req_ready), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        repeat (25) step(4'b0000, 1'b1, 1'b0, 1'b0, 0, 16'h0);
        repeat (10) step(4'b1111, 1'b1, 1'b0, 1'b0, 0, 16'h0);
        drain();

        step(4'b0100, 1'b1, 1'b0, 1'b0, 1, 16'h3C00);
        check("single_req_ready", 32'(req_ready), 32'h4);
        drain();

        for (int i = 0; i < 6; i++) begin
            step(4'b0010, 1'b1, 1'b0, 1'b0, 1, (i % 2 == 1) ? (16'hC000 | 16'(i)) : (16'h1000 | 16'(i)));
        end
        drain();
        check("overflow_count_three", 32'(overflow_count), 32'd3);

        step(4'b0000, 1'b1, 1'b1, 1'b0, 0, 16'h0);
        repeat (5) step(4'b0000, 1'b1, 1'b0, 1'b0, 0, 16'h0);
        check("orphan_sticky", 32'(orphan_err), 32'd1);
        check("orphan_no_resp", 32'(resp_valid), 32'd0);

        repeat (300) step(4'($urandom), ($urandom_range(0, 3) != 0), 1'b0, 1'b0, 2, 16'h0);
        drain();

        repeat (10) step(4'b1111, 1'b0, 1'b0, 1'b0, 0, 16'h0);
        step(4'b0000, 1'b0, 1'b0, 1'b1, 0, 16'h0);
        step(4'b1111, 1'b1, 1'b0, 1'b0, 0, 16'h0);
        check("post_reset_grant0", 32'(req_ready), 32'h1);
        repeat (40) step(4'($urandom), ($urandom_range(0, 3) != 0), 1'b0, 1'b0, 2, 16'h0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
